// File: rtl/button_pwm_led_ctrl.sv
// Front-panel controller: per-channel button debounce, short/long press
// classification, OFF/SOLID/BLINK mode FSM and PWM-dimmed active-low LED drive.
module button_pwm_led_ctrl #(
    parameter int unsigned NUM_CH          = 3,
    parameter int unsigned PWM_BITS        = 8,
    parameter int unsigned LEVEL_STEP      = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 12000,
    parameter int unsigned LONG_CYCLES     = 6_000_000,
    parameter int unsigned BLINK_CYCLES    = 3_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          button_i,
    output logic [NUM_CH-1:0]          led_o,
    output logic [2*NUM_CH-1:0]        mode_o,
    output logic [PWM_BITS*NUM_CH-1:0] level_o
);

    localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned HoldW  = $clog2(LONG_CYCLES + 1);
    localparam int unsigned BlinkW = $clog2(BLINK_CYCLES) + 1;
    localparam int unsigned SumW   = PWM_BITS + 1;

    localparam logic [DbW-1:0]      DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0]    HoldMax   = HoldW'(LONG_CYCLES);
    localparam logic [HoldW-1:0]    HoldLast  = HoldW'(LONG_CYCLES - 1);
    localparam logic [BlinkW-1:0]   BlinkLast = BlinkW'(BLINK_CYCLES - 1);
    localparam logic [SumW-1:0]     LevelMax  = SumW'((1 << PWM_BITS) - 1);
    localparam logic [SumW-1:0]     StepSum   = SumW'(LEVEL_STEP);
    localparam logic [PWM_BITS-1:0] StepLvl   = PWM_BITS'(LEVEL_STEP);

    typedef enum logic [1:0] {
        ModeOff   = 2'd0,
        ModeSolid = 2'd1,
        ModeBlink = 2'd2
    } mode_e;

    // Input conditioning
    logic [NUM_CH-1:0] sync1_q, sync1_d;
    logic [NUM_CH-1:0] sync2_q, sync2_d;
    logic [NUM_CH-1:0] db_q, db_d;
    logic [DbW-1:0]    db_cnt_q [NUM_CH];
    logic [DbW-1:0]    db_cnt_d [NUM_CH];

    // Press classification
    logic [HoldW-1:0]  hold_q [NUM_CH];
    logic [HoldW-1:0]  hold_d [NUM_CH];
    logic [NUM_CH-1:0] short_q, short_d;
    logic [NUM_CH-1:0] long_q, long_d;

    // Channel state
    mode_e             mode_q  [NUM_CH];
    mode_e             mode_d  [NUM_CH];
    logic [PWM_BITS-1:0] level_q [NUM_CH];
    logic [PWM_BITS-1:0] level_d [NUM_CH];
    logic [NUM_CH-1:0] phase_q, phase_d;
    logic [NUM_CH-1:0] enter_blink;

    // Shared timebases and output register
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
    logic                blink_tick;
    logic [NUM_CH-1:0]   led_q, led_d;

    always_comb begin
        logic [SumW-1:0] sum;

        sum         = '0;
        sync1_d     = button_i;
        sync2_d     = sync1_q;
        db_d        = db_q;
        short_d     = '0;
        long_d      = '0;
        phase_d     = phase_q;
        enter_blink = '0;
        led_d       = '1;
        pwm_d       = pwm_q + 1'b1;
        blink_tick  = (blink_cnt_q == BlinkLast);

        for (int i = 0; i < NUM_CH; i++) begin
            db_cnt_d[i] = '0;
            hold_d[i]   = '0;
            mode_d[i]   = mode_q[i];
            level_d[i]  = level_q[i];

            // Debounce: accept the synced value after it differs for DEBOUNCE_CYCLES cycles
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end

            if (!db_q[i]) begin
                hold_d[i] = (hold_q[i] == HoldMax) ? hold_q[i] : hold_q[i] + 1'b1;
            end

            // A nonzero hold count with db released only survives the cycle after release
            short_d[i] = db_q[i] && (hold_q[i] != '0) && (hold_q[i] < HoldMax);
            long_d[i]  = !db_q[i] && (hold_q[i] == HoldLast);

            sum = {1'b0, level_q[i]} + StepSum;
            if (short_q[i]) begin
                case (mode_q[i])
                    ModeOff: begin
                        mode_d[i]  = ModeSolid;
                        level_d[i] = StepLvl;
                    end
                    default: begin
                        if (sum > LevelMax) begin
                            mode_d[i]  = ModeOff;
                            level_d[i] = '0;
                        end else begin
                            level_d[i] = sum[PWM_BITS-1:0];
                        end
                    end
                endcase
            end else if (long_q[i]) begin
                case (mode_q[i])
                    ModeSolid: begin
                        mode_d[i]      = ModeBlink;
                        enter_blink[i] = 1'b1;
                    end
                    ModeBlink: mode_d[i] = ModeSolid;
                    default:   mode_d[i] = mode_q[i];
                endcase
            end

            if (enter_blink[i]) begin
                phase_d[i] = 1'b1;
            end else if (blink_tick) begin
                phase_d[i] = ~phase_q[i];
            end

            led_d[i] = ~((mode_q[i] != ModeOff) && (pwm_q < level_q[i]) &&
                         ((mode_q[i] != ModeBlink) || phase_q[i]));
        end

        blink_cnt_d = (|enter_blink || blink_tick) ? '0 : blink_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            db_q        <= '1;
            short_q     <= '0;
            long_q      <= '0;
            phase_q     <= '0;
            pwm_q       <= '0;
            blink_cnt_q <= '0;
            led_q       <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                db_cnt_q[i] <= '0;
                hold_q[i]   <= '0;
                mode_q[i]   <= ModeOff;
                level_q[i]  <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            short_q     <= short_d;
            long_q      <= long_d;
            phase_q     <= phase_d;
            pwm_q       <= pwm_d;
            blink_cnt_q <= blink_cnt_d;
            led_q       <= led_d;
            for (int i = 0; i < NUM_CH; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
                hold_q[i]   <= hold_d[i];
                mode_q[i]   <= mode_d[i];
                level_q[i]  <= level_d[i];
            end
        end
    end

    assign led_o = led_q;

    always_comb begin
        mode_o  = '0;
        level_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mode_o[2*i +: 2]               = mode_q[i];
            level_o[PWM_BITS*i +: PWM_BITS] = level_q[i];
        end
    end

endmodule
